ksa_engine: RTL

Parametrised RC4 key-scheduling engine: optionally initialises the state array (S[k] = k), then performs the full key-scheduling shuffle over a single-port state RAM. It is the generalised successor of the fixed 256-entry, 24-bit-key shuffle task. It adds three things over that task:
- configurable state depth and key length;
- an optional in-block init pass;
- key capture at start, plus an abort.

It sits between the top-level task sequencer and the S-memory port mux.

---
 rtl/ksa_engine.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ksa_engine.sv
// RC4 key-scheduling engine over a single-port state RAM: optional S[k]=k init pass, then the swap shuffle.
// Registered Moore outputs; 1 cycle per init write, 6 cycles per shuffle step; abort returns to IDLE at once.
module ksa_engine #(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   init_en,
  input  logic                   abort,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [ADDR_W-1:0]      data_in,
  output logic [ADDR_W-1:0]      address,
  output logic [ADDR_W-1:0]      data_out,
  output logic                   wr_en,
  output logic                   task_on,
  output logic                   fin_strobe
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [2:0] {IDLE, INIT, RD_I, LAT_I, RD_J, LAT_J, WR_I, WR_J} state_t;

  state_t                 state, state_nxt;
  logic [ADDR_W:0]        i, i_nxt;
  logic [ADDR_W-1:0]      j, j_nxt;
  logic [ADDR_W-1:0]      si, si_nxt;
  logic [KW-1:0]          k, k_nxt;
  logic [8*KEY_BYTES-1:0] key, key_nxt;
  logic [ADDR_W-1:0]      addr_nxt, dout_nxt;
  logic                   wr_nxt, busy_nxt, fin_nxt;
  logic [7:0]             kb;
  logic [ADDR_W-1:0]      kb_w;

  always_comb begin
    kb = '0;
    for (int b = 0; b < KEY_BYTES; b++)
      if (k == KW'(b)) kb = key[8*(KEY_BYTES-1-b) +: 8];
  end

  // Key byte is zero-extended or truncated to the state width.
  assign kb_w = ADDR_W'(kb);

  always_comb begin
    state_nxt = state;
    i_nxt     = i;
    j_nxt     = j;
    k_nxt     = k;
    si_nxt    = si;
    key_nxt   = key;
    addr_nxt  = address;
    dout_nxt  = data_out;
    wr_nxt    = 1'b0;
    busy_nxt  = 1'b1;
    fin_nxt   = 1'b0;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (start && !abort) begin
          key_nxt  = secret_key;
          i_nxt    = '0;
          j_nxt    = '0;
          k_nxt    = '0;
          busy_nxt = 1'b1;
          addr_nxt = '0;
          dout_nxt = '0;
          if (init_en) begin
            state_nxt = INIT;
            wr_nxt    = 1'b1;
          end else begin
            state_nxt = RD_I;
          end
        end
      end
      INIT: begin
        if (i == LAST) begin
          i_nxt     = '0;
          addr_nxt  = '0;
          state_nxt = RD_I;
        end else begin
          i_nxt    = i + 1'b1;
          addr_nxt = i_nxt[ADDR_W-1:0];
          dout_nxt = i_nxt[ADDR_W-1:0];
          wr_nxt   = 1'b1;
        end
      end
      RD_I:  state_nxt = LAT_I;
      LAT_I: begin
        si_nxt    = data_in;
        j_nxt     = j + data_in + kb_w;
        addr_nxt  = j_nxt;
        state_nxt = RD_J;
      end
      RD_J:  state_nxt = LAT_J;
      // data_in here is S[j]; it goes straight into the write-data register.
      LAT_J: begin
        addr_nxt  = i[ADDR_W-1:0];
        dout_nxt  = data_in;
        wr_nxt    = 1'b1;
        state_nxt = WR_I;
      end
      WR_I: begin
        addr_nxt  = j;
        dout_nxt  = si;
        wr_nxt    = 1'b1;
        state_nxt = WR_J;
      end
      WR_J: begin
        i_nxt = i + 1'b1;
        k_nxt = (k == KW'(KEY_BYTES-1)) ? '0 : k + 1'b1;
        if (i == LAST) begin
          state_nxt = IDLE;
          fin_nxt   = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          addr_nxt  = i_nxt[ADDR_W-1:0];
          state_nxt = RD_I;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      wr_nxt    = 1'b0;
      busy_nxt  = 1'b0;
      fin_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      i          <= '0;
      j          <= '0;
      k          <= '0;
      si         <= '0;
      key        <= '0;
      address    <= '0;
      data_out   <= '0;
      wr_en      <= 1'b0;
      task_on    <= 1'b0;
      fin_strobe <= 1'b0;
    end else begin
      state      <= state_nxt;
      i          <= i_nxt;
      j          <= j_nxt;
      k          <= k_nxt;
      si         <= si_nxt;
      key        <= key_nxt;
      address    <= addr_nxt;
      data_out   <= dout_nxt;
      wr_en      <= wr_nxt;
      task_on    <= busy_nxt;
      fin_strobe <= fin_nxt;
    end
  end

endmodule
